// File: rtl/ff_jk.sv
// ff_jk: a bank of WIDTH independent positive-edge JK flip-flops with
// complementary outputs. Reset is synchronous and active-low.
//
// Optional feature, enabled by defining the macro FFJK_TOGGLE_CNT_EN:
//   toggle_cnt counts the clock edges on which q changed in any bit.
//   It saturates at all-ones and clears on reset.
// With the macro undefined, the toggle_cnt port and its counter are absent.
// The q/qn behaviour is the same in both builds.
module ff_jk #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int               CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn
`ifdef FFJK_TOGGLE_CNT_EN
   ,
   output logic [CNT_W-1:0] toggle_cnt
`endif
);

   // Reject configurations that cannot be built.
   if (WIDTH < 1) begin : g_bad_width
      $error("ff_jk: WIDTH must be at least 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("ff_jk: CNT_W must be at least 1");
   end

   // The declaration value sets the power-up state. Outputs are defined
   // before the first reset. FPGA flops take this value as their init value.
   logic [WIDTH-1:0] r_q = RESET_VAL;
   logic [WIDTH-1:0] w_q_next;

   // Each bit has its own JK next-state mux. No bit depends on another.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_q_next[gi] = ( j[gi] &&  k[gi]) ? ~r_q[gi] :   // toggle
                            ( j[gi] && !k[gi]) ? 1'b1     :   // set
                            (!j[gi] &&  k[gi]) ? 1'b0     :   // reset
                                                 r_q[gi];     // hold
   end

   // State register. Only rst_n == 0 resets the bank. Any other rst_n value
   // lets the flops update normally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= RESET_VAL;
      end else begin
         r_q <= w_q_next;
      end
   end

   // qn is derived combinationally from q, so the two can never disagree.
   assign q  = r_q;
   assign qn = ~r_q;

`ifdef FFJK_TOGGLE_CNT_EN
   logic [CNT_W-1:0] r_cnt = '0;
   logic             w_changed;
   logic             w_cnt_sat;

   assign w_changed = |(w_q_next ^ r_q);
   assign w_cnt_sat = &r_cnt;

   // Count the edges that change q. Reset edges do not count. The counter
   // stops at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_changed && !w_cnt_sat) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign toggle_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_ff_jk.sv
// Directed testbench for ff_jk.
// u_dut1 is the classic single JK flop: WIDTH=1, RESET_VAL=0.
// u_dut2 is a 4-bit bank: RESET_VAL=4'b1010, CNT_W=3, so the counter
// saturates after only a few edges.
module tb_ff_jk;

   logic        clk = 1'b0;
   logic        rst1_n;
   logic        j1, k1;
   logic        q1, qn1;
   logic        rst2_n;
   logic [3:0]  j2, k2;
   logic [3:0]  q2, qn2;
`ifdef FFJK_TOGGLE_CNT_EN
   logic [15:0] cnt1;
   logic [2:0]  cnt2;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ff_jk #(.WIDTH(1), .RESET_VAL(1'b0), .CNT_W(16)) u_dut1 (
      .clk   (clk),
      .rst_n (rst1_n),
      .j     (j1),
      .k     (k1),
      .q     (q1),
      .qn    (qn1)
`ifdef FFJK_TOGGLE_CNT_EN
      ,
      .toggle_cnt (cnt1)
`endif
   );

   ff_jk #(.WIDTH(4), .RESET_VAL(4'b1010), .CNT_W(3)) u_dut2 (
      .clk   (clk),
      .rst_n (rst2_n),
      .j     (j2),
      .k     (k2),
      .q     (q2),
      .qn    (qn2)
`ifdef FFJK_TOGGLE_CNT_EN
      ,
      .toggle_cnt (cnt2)
`endif
   );

   // Advance to just after the next rising edge so outputs have settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_powerup();
      n_checks++;
      if (q2 !== 4'b1010) begin
         $display("FAIL powerup_q2: got %b expected 1010", q2);
         n_fail++;
      end
      n_checks++;
      if (qn2 !== 4'b0101) begin
         $display("FAIL powerup_qn2: got %b expected 0101", qn2);
         n_fail++;
      end
      n_checks++;
      if (q1 !== 1'b0) begin
         $display("FAIL powerup_q1: got %b expected 0", q1);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      rst1_n = 1'b0; j1 = 1'b1; k1 = 1'b1;
      tick();
      n_checks++;
      if (q1 !== 1'b0 || qn1 !== 1'b1) begin
         $display("FAIL reset: q=%b qn=%b expected q=0 qn=1", q1, qn1);
         n_fail++;
      end
`ifdef FFJK_TOGGLE_CNT_EN
      n_checks++;
      if (cnt1 !== 16'd0) begin
         $display("FAIL reset_cnt: got %0d expected 0", cnt1);
         n_fail++;
      end
`endif
      rst1_n = 1'b1;
   endtask

   task automatic test_hold();
      j1 = 1'b0; k1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (q1 !== 1'b0 || qn1 !== 1'b1) begin
            $display("FAIL hold[%0d]: q=%b qn=%b expected q=0 qn=1", i, q1, qn1);
            n_fail++;
         end
      end
   endtask

   task automatic test_reset_mode();
      j1 = 1'b1; k1 = 1'b0;
      tick();
      n_checks++;
      if (q1 !== 1'b1) begin
         $display("FAIL reset_mode_pre: got %b expected 1", q1);
         n_fail++;
      end
      j1 = 1'b0; k1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (q1 !== 1'b0 || qn1 !== 1'b1) begin
            $display("FAIL reset_mode[%0d]: q=%b qn=%b expected q=0 qn=1", i, q1, qn1);
            n_fail++;
         end
      end
`ifdef FFJK_TOGGLE_CNT_EN
      n_checks++;
      if (cnt1 !== 16'd2) begin
         $display("FAIL reset_mode_cnt: got %0d expected 2", cnt1);
         n_fail++;
      end
`endif
   endtask

   task automatic test_set_mode();
      j1 = 1'b1; k1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (q1 !== 1'b1 || qn1 !== 1'b0) begin
            $display("FAIL set_mode[%0d]: q=%b qn=%b expected q=1 qn=0", i, q1, qn1);
            n_fail++;
         end
      end
`ifdef FFJK_TOGGLE_CNT_EN
      n_checks++;
      if (cnt1 !== 16'd3) begin
         $display("FAIL set_mode_cnt: got %0d expected 3", cnt1);
         n_fail++;
      end
`endif
   endtask

   task automatic test_toggle();
      logic [5:0] exp_seq;
      exp_seq = 6'b101010;               // bit i is q after edge i: 0,1,0,1,0,1
      j1 = 1'b1; k1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++;
         if (q1 !== exp_seq[i] || qn1 !== ~exp_seq[i]) begin
            $display("FAIL toggle[%0d]: q=%b qn=%b expected q=%b", i, q1, qn1, exp_seq[i]);
            n_fail++;
         end
      end
`ifdef FFJK_TOGGLE_CNT_EN
      n_checks++;
      if (cnt1 !== 16'd9) begin
         $display("FAIL toggle_cnt: got %0d expected 9", cnt1);
         n_fail++;
      end
`endif
   endtask

   task automatic test_reset_during_toggle();
      j1 = 1'b1; k1 = 1'b1;
      tick();                            // 1 -> 0
      tick();                            // 0 -> 1
      n_checks++;
      if (q1 !== 1'b1) begin
         $display("FAIL rst_toggle_pre: got %b expected 1", q1);
         n_fail++;
      end
      rst1_n = 1'b0;
      tick();
      n_checks++;
      if (q1 !== 1'b0 || qn1 !== 1'b1) begin
         $display("FAIL rst_toggle_reset: q=%b qn=%b expected q=0 qn=1", q1, qn1);
         n_fail++;
      end
`ifdef FFJK_TOGGLE_CNT_EN
      n_checks++;
      if (cnt1 !== 16'd0) begin
         $display("FAIL rst_toggle_cnt_clr: got %0d expected 0", cnt1);
         n_fail++;
      end
`endif
      rst1_n = 1'b1;
      tick();
      n_checks++;
      if (q1 !== 1'b1) begin
         $display("FAIL rst_toggle_resume1: got %b expected 1", q1);
         n_fail++;
      end
      tick();
      n_checks++;
      if (q1 !== 1'b0) begin
         $display("FAIL rst_toggle_resume2: got %b expected 0", q1);
         n_fail++;
      end
`ifdef FFJK_TOGGLE_CNT_EN
      n_checks++;
      if (cnt1 !== 16'd2) begin
         $display("FAIL rst_toggle_cnt: got %0d expected 2", cnt1);
         n_fail++;
      end
`endif
   endtask

   task automatic test_between_edges();
      // Pulse j/k between edges only: the pulse must be ignored.
      j1 = 1'b0; k1 = 1'b0;
      #2 j1 = 1'b1; k1 = 1'b1;
      #3 j1 = 1'b0; k1 = 1'b0;
      tick();
      n_checks++;
      if (q1 !== 1'b0) begin
         $display("FAIL between_edges_pulse: got %b expected 0", q1);
         n_fail++;
      end
      // Set j just before the edge and drop it right after: the edge captures it.
      #7 j1 = 1'b1;
      tick();
      j1 = 1'b0;
      n_checks++;
      if (q1 !== 1'b1) begin
         $display("FAIL between_edges_sample: got %b expected 1", q1);
         n_fail++;
      end
      tick();
      n_checks++;
      if (q1 !== 1'b1) begin
         $display("FAIL between_edges_hold: got %b expected 1", q1);
         n_fail++;
      end
   endtask

   task automatic test_per_bit();
      n_checks++;
      if (q2 !== 4'b1010) begin
         $display("FAIL per_bit_start: got %b expected 1010", q2);
         n_fail++;
      end
      j2 = 4'b0011; k2 = 4'b0101;
      tick();
      n_checks++;
      if (q2 !== 4'b1011 || qn2 !== 4'b0100) begin
         $display("FAIL per_bit_mix: q=%b qn=%b expected q=1011 qn=0100", q2, qn2);
         n_fail++;
      end
      j2 = 4'b1111; k2 = 4'b1111;
      tick();
      n_checks++;
      if (q2 !== 4'b0100) begin
         $display("FAIL per_bit_toggle_all: got %b expected 0100", q2);
         n_fail++;
      end
`ifdef FFJK_TOGGLE_CNT_EN
      n_checks++;
      if (cnt2 !== 3'd2) begin
         $display("FAIL per_bit_cnt: got %0d expected 2", cnt2);
         n_fail++;
      end
`endif
      rst2_n = 1'b0;
      tick();
      n_checks++;
      if (q2 !== 4'b1010 || qn2 !== 4'b0101) begin
         $display("FAIL per_bit_reset: q=%b qn=%b expected q=1010 qn=0101", q2, qn2);
         n_fail++;
      end
`ifdef FFJK_TOGGLE_CNT_EN
      n_checks++;
      if (cnt2 !== 3'd0) begin
         $display("FAIL per_bit_cnt_clr: got %0d expected 0", cnt2);
         n_fail++;
      end
`endif
      rst2_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      // Nine toggle edges starting from 1010. An odd count leaves q at 0101.
      // The 3-bit counter must stop at 7 instead of wrapping.
      j2 = 4'b1111; k2 = 4'b1111;
      for (int i = 0; i < 7; i++) tick();
      n_checks++;
      if (q2 !== 4'b0101) begin
         $display("FAIL b2b_q7: got %b expected 0101", q2);
         n_fail++;
      end
`ifdef FFJK_TOGGLE_CNT_EN
      n_checks++;
      if (cnt2 !== 3'd7) begin
         $display("FAIL b2b_cnt7: got %0d expected 7", cnt2);
         n_fail++;
      end
`endif
      tick();
      tick();
      n_checks++;
      if (q2 !== 4'b0101) begin
         $display("FAIL b2b_q9: got %b expected 0101", q2);
         n_fail++;
      end
`ifdef FFJK_TOGGLE_CNT_EN
      n_checks++;
      if (cnt2 !== 3'd7) begin
         $display("FAIL b2b_cnt_sat: got %0d expected 7", cnt2);
         n_fail++;
      end
`endif
   endtask

   initial begin
      rst1_n = 1'b1; j1 = 1'b0; k1 = 1'b0;
      rst2_n = 1'b1; j2 = 4'b0000; k2 = 4'b0000;
      #1;
      test_powerup();
      test_reset();
      test_hold();
      test_reset_mode();
      test_set_mode();
      test_toggle();
      test_reset_during_toggle();
      test_between_edges();
      test_per_bit();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ff_jk.md
Name: ff_jk

Overview:
- Bank of WIDTH independent positive-edge JK flip-flops with complementary outputs.
- Generic storage/toggle primitive for small control logic, e.g. dividers, toggles and set/clear flags.
- One clock domain; synchronous active-low reset.
- WIDTH=1 is the classic single JK flip-flop.

Parameters:
- WIDTH, 1, number of independent JK bits.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset and used as the simulation power-up value.
- CNT_W, 16, width of the toggle-event counter (used only with FFJK_TOGGLE_CNT_EN).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled at the rising edge of clk.
- j  input  WIDTH  per-bit J (set) input.
- k  input  WIDTH  per-bit K (reset) input.
- q  output  WIDTH  registered flip-flop state.
- qn  output  WIDTH  complement of q.
- toggle_cnt  output  CNT_W  count of clock cycles in which q changed (present only with FFJK_TOGGLE_CNT_EN).

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. No asynchronous path of any kind.
- Reset: at a rising edge with rst_n==0, q <= RESET_VAL regardless of j/k.
  - qn = ~RESET_VAL.
  - toggle_cnt <= 0.
- Normal operation: at a rising edge with rst_n==1, each bit i is updated independently:
  - j=0,k=0: hold, q[i] unchanged.
  - j=0,k=1: reset, q[i] <= 0.
  - j=1,k=0: set, q[i] <= 1.
  - j=1,k=1: toggle, q[i] <= ~q[i].
- Timing and latency:
  - j/k are sampled only at the rising edge; changes between edges have no effect.
  - q changes one edge after the inputs are presented, i.e. it reflects the j/k values present at that edge.
- qn is combinational ~q at all times, never independently registered, so q and qn are always complementary.
- Power-up: q is initialised to RESET_VAL in simulation, so outputs are defined before the first reset.
  - A floating/unknown rst_n does not corrupt state: only rst_n==0 resets.
- Continuous toggle (j=k=1 held): q alternates every rising edge, giving clk/2 on each bit.
- Reset asserted while bits are toggling: reset wins on that edge; toggling resumes on the first edge with rst_n==1 and j=k=1.
- No glitches on q: q is driven only by flops.

Optional Feature:
- Macro FFJK_TOGGLE_CNT_EN.
- When defined:
  - Adds output toggle_cnt[CNT_W-1:0].
  - It increments by 1 on every non-reset rising edge where the next q differs from the current q in any bit.
  - It saturates at all-ones and clears to 0 on reset.
  - It is registered, updating on the same edge as q.
- When not defined: the port and counter logic are absent; q/qn behaviour is identical.

Test Plan:
- Reset: rst_n=0 for one edge with j=1,k=1, WIDTH=1, RESET_VAL=0 -> q=0, qn=1 after the edge; toggle_cnt=0.
- Hold: after reset apply j=0,k=0 for 3 edges -> q stays 0, qn stays 1.
- Reset mode: set q=1, then j=0,k=1 -> q=0 after the next edge; holds 0 on further edges.
- Set mode: j=1,k=0 -> q=1, qn=0 after the next edge; remains 1 for the following 2 edges.
- Toggle mode: j=1,k=1 for 6 edges starting from q=1 -> q sequence 0,1,0,1,0,1; toggle_cnt increases by 6 (counter enabled). Assert rst_n=0 mid-sequence -> q=0 on that edge.
- Per-bit independence: WIDTH=4, RESET_VAL=4'b1010, j=4'b0011, k=4'b0101 -> bit0 toggles, bit1 sets, bit2 resets, bit3 holds: q goes 1010 -> 1011.
